pnr_fifo_drain_master: RTL and testbench

- System-bus initiator that drains the PNR ADC sample FIFO through the register slave's FIFO window.
- Polls the FIFO counter register and issues burst reads of the FIFO data register.
- Delivers each 14-bit sample on a valid/ready stream.
- Also issues FIFO reset write sequences on request. Sits beside the bus interconnect, driving the same sys_* bus the PS uses.

---
 rtl/pnr_fifo_drain_master.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_pnr_fifo_drain_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pnr_fifo_drain_master.sv
// System-bus initiator that polls the PNR FIFO counter, burst-reads the FIFO data
// window into a one-deep valid/ready stream, and issues FIFO reset write pairs.
module pnr_fifo_drain_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [19:0] OFF_DATA    = 20'h00070,
    parameter logic [19:0] OFF_CNT     = 20'h00074,
    parameter logic [19:0] OFF_RST     = 20'h00078,
    parameter int unsigned MAX_BURST   = 64,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        flush_i,
    input  logic        err_clr_i,
    output logic [31:0] sys_addr_o,
    output logic [31:0] sys_wdata_o,
    output logic        sys_wen_o,
    output logic        sys_ren_o,
    input  logic [31:0] sys_rdata_i,
    input  logic        sys_err_i,
    input  logic        sys_ack_i,
    output logic [13:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] words_read_o
);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
    localparam logic [15:0]   BURST_MAX = 16'(MAX_BURST);

    localparam logic [31:0] ADDR_DATA = BASE_ADDR | {12'h000, OFF_DATA};
    localparam logic [31:0] ADDR_CNT  = BASE_ADDR | {12'h000, OFF_CNT};
    localparam logic [31:0] ADDR_RST  = BASE_ADDR | {12'h000, OFF_RST};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH1 = 3'd1,
        ST_FLUSH0 = 3'd2,
        ST_POLL   = 3'd3,
        ST_DREAD  = 3'd4,
        ST_HOLD   = 3'd5,
        ST_WAITP  = 3'd6
    } state_t;

    state_t        state_q,       state_d;
    logic [31:0]   addr_q,        addr_d;
    logic [31:0]   wdata_q,       wdata_d;
    logic          wen_q,         wen_d;
    logic          ren_q,         ren_d;
    logic [TW-1:0] tmo_q,         tmo_d;
    logic [GW-1:0] gap_q,         gap_d;
    logic [1:0]    hold_q,        hold_d;
    logic [15:0]   burst_q,       burst_d;
    logic [13:0]   data_q,        data_d;
    logic          valid_q,       valid_d;
    logic          busy_q,        busy_d;
    logic          err_q,         err_d;
    logic [31:0]   words_q,       words_d;
    logic          flush_pend_q,  flush_pend_d;
    logic          flush_again_q, flush_again_d;

    logic          ack_seen_s;
    logic          ack_ok_s;
    logic          bus_fail_s;
    logic          err_set_s;
    logic [15:0]   burst_rem_s;

    // An ack in the request cycle itself is not a response to this request.
    assign ack_seen_s = sys_ack_i && !ren_q && !wen_q;
    assign ack_ok_s   = ack_seen_s && !sys_err_i;
    assign bus_fail_s = (ack_seen_s && sys_err_i) || (!ack_seen_s && (tmo_q == TMO_LAST));

    // Next-state and next-output logic for the drain sequencer.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wen_d         = 1'b0;
        ren_d         = 1'b0;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        hold_d        = hold_q;
        burst_d       = burst_q;
        data_d        = data_q;
        words_d       = words_q;
        err_set_s     = 1'b0;
        burst_rem_s   = burst_q - 16'd1;
        flush_pend_d  = flush_pend_q | flush_i;
        if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A request arriving mid-sequence must buy one more full sequence.
        if (flush_i && ((state_q == ST_FLUSH1) || (state_q == ST_FLUSH0))) begin
            flush_again_d = 1'b1;
        end else begin
            flush_again_d = flush_again_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (err_q) begin
                    state_d = ST_IDLE;
                end else if (flush_pend_q) begin
                    state_d = ST_FLUSH1;
                    addr_d  = ADDR_RST;
                    wdata_d = 32'h0000_0001;
                    wen_d   = 1'b1;
                    tmo_d   = '0;
                end else if (enable_i && !valid_q) begin
                    state_d = ST_POLL;
                    addr_d  = ADDR_CNT;
                    ren_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH1: begin
                if (ack_ok_s) begin
                    state_d = ST_FLUSH0;
                    wdata_d = 32'h0000_0000;
                    wen_d   = 1'b1;
                    tmo_d   = '0;
                end else if (bus_fail_s) begin
                    err_set_s     = 1'b1;
                    flush_again_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_FLUSH0: begin
                if (ack_ok_s) begin
                    flush_pend_d  = flush_again_q | flush_i;
                    flush_again_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (bus_fail_s) begin
                    err_set_s     = 1'b1;
                    flush_again_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_POLL: begin
                if (ack_ok_s) begin
                    if (!enable_i || flush_pend_q || flush_i) begin
                        state_d = ST_IDLE;
                    end else if (sys_rdata_i == 32'd0) begin
                        state_d = ST_WAITP;
                        gap_d   = '0;
                    end else begin
                        state_d = ST_DREAD;
                        addr_d  = ADDR_DATA;
                        ren_d   = 1'b1;
                        tmo_d   = '0;
                        if (sys_rdata_i > 32'(MAX_BURST)) begin
                            burst_d = BURST_MAX;
                        end else begin
                            burst_d = sys_rdata_i[15:0];
                        end
                    end
                end else if (bus_fail_s) begin
                    err_set_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DREAD: begin
                if (ack_ok_s) begin
                    data_d  = sys_rdata_i[13:0];
                    valid_d = 1'b1;
                    words_d = words_q + 32'd1;
                    hold_d  = 2'd1;
                    state_d = ST_HOLD;
                end else if (bus_fail_s) begin
                    err_set_s = 1'b1;
                    burst_d   = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_HOLD: begin
                // Leave only once the sample is taken and the FIFO pop has settled.
                if ((!valid_q || m_ready_i) && (hold_q == 2'd2)) begin
                    burst_d = burst_rem_s;
                    if ((burst_rem_s != 16'd0) && enable_i && !flush_pend_q && !flush_i) begin
                        state_d = ST_DREAD;
                        addr_d  = ADDR_DATA;
                        ren_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (hold_q != 2'd2) begin
                    hold_d = hold_q + 2'd1;
                end else begin
                    hold_d = hold_q;
                end
            end
            ST_WAITP: begin
                if (!enable_i || flush_pend_q) begin
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_clr_i) begin
            err_d = 1'b0;
        end else if (err_set_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= BASE_ADDR;
            wdata_q       <= 32'h0000_0000;
            wen_q         <= 1'b0;
            ren_q         <= 1'b0;
            tmo_q         <= '0;
            gap_q         <= '0;
            hold_q        <= 2'd0;
            burst_q       <= 16'd0;
            data_q        <= 14'd0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            words_q       <= 32'd0;
            flush_pend_q  <= 1'b0;
            flush_again_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wen_q         <= wen_d;
            ren_q         <= ren_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            hold_q        <= hold_d;
            burst_q       <= burst_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            words_q       <= words_d;
            flush_pend_q  <= flush_pend_d;
            flush_again_q <= flush_again_d;
        end
    end

    assign sys_addr_o   = addr_q;
    assign sys_wdata_o  = wdata_q;
    assign sys_wen_o    = wen_q;
    assign sys_ren_o    = ren_q;
    assign m_data_o     = data_q;
    assign m_valid_o    = valid_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign words_read_o = words_q;

endmodule

// File: tb/tb_pnr_fifo_drain_master.sv
// Directed bench for pnr_fifo_drain_master with a one-cycle-latency register responder.
module tb_pnr_fifo_drain_master;
    localparam logic [31:0] A_DATA = 32'h0000_0070;
    localparam logic [31:0] A_CNT  = 32'h0000_0074;
    localparam logic [31:0] A_RST  = 32'h0000_0078;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic [31:0] sys_addr_o;
    logic [31:0] sys_wdata_o;
    logic        sys_wen_o;
    logic        sys_ren_o;
    logic [31:0] sys_rdata_i = 32'h0;
    logic        sys_err_i = 1'b0;
    logic        sys_ack_i = 1'b0;
    logic [13:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic        busy_o;
    logic        err_o;
    logic [31:0] words_read_o;

    always #5 clk_i = ~clk_i;

    pnr_fifo_drain_master dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .err_clr_i(err_clr_i), .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o),
        .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i),
        .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
        .err_o(err_o), .words_read_o(words_read_o)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_reqs, n_cnt_reads, n_data_reads, n_writes;
    int          last_cnt_cyc, cnt_period, last_data_cyc, min_data_gap;
    int          run_len, req_while_valid;
    int          runs[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [13:0] recv[$];
    logic [31:0] cnt_q[$];
    logic [31:0] data_next = 32'h0;
    logic [31:0] data_step = 32'h1;
    bit          rsp_mute = 1'b0;
    bit          data_err_once = 1'b0;
    bit          rsp_pend = 1'b0;
    bit          rsp_rd = 1'b0;
    logic [31:0] rsp_addr = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus and stream monitor: sees the values present during the cycle that just ended.
    initial forever begin
        @(posedge clk_i);
        cyc++;
        if (!rst_i) begin
            if (m_valid_o && m_ready_i) recv.push_back(m_data_o);
            if (sys_ren_o || sys_wen_o) begin
                n_reqs++;
                if (m_valid_o) req_while_valid++;
                if (sys_wen_o) begin
                    n_writes++;
                    wr_addr.push_back(sys_addr_o);
                    wr_data.push_back(sys_wdata_o);
                end else if (sys_addr_o == A_CNT) begin
                    n_cnt_reads++;
                    if (last_cnt_cyc >= 0) cnt_period = cyc - last_cnt_cyc;
                    last_cnt_cyc = cyc;
                    if (run_len > 0) runs.push_back(run_len);
                    run_len = 0;
                end else if (sys_addr_o == A_DATA) begin
                    n_data_reads++;
                    run_len++;
                    if (last_data_cyc >= 0 && (cyc - last_data_cyc) < min_data_gap)
                        min_data_gap = cyc - last_data_cyc;
                    last_data_cyc = cyc;
                end
            end
        end
    end

    // Register responder: acks every request in the following cycle unless muted.
    initial forever begin
        @(negedge clk_i);
        sys_ack_i   = 1'b0;
        sys_err_i   = 1'b0;
        sys_rdata_i = 32'h0;
        if (rsp_pend) begin
            rsp_pend  = 1'b0;
            sys_ack_i = 1'b1;
            if (rsp_rd && rsp_addr == A_CNT) begin
                sys_rdata_i = (cnt_q.size() > 0) ? cnt_q.pop_front() : 32'h0;
            end else if (rsp_rd && rsp_addr == A_DATA) begin
                if (data_err_once) begin
                    sys_err_i     = 1'b1;
                    data_err_once = 1'b0;
                end else begin
                    sys_rdata_i = data_next;
                    data_next   = data_next + data_step;
                end
            end
        end
        if (!rsp_mute && (sys_ren_o || sys_wen_o)) begin
            rsp_pend = 1'b1;
            rsp_rd   = sys_ren_o;
            rsp_addr = sys_addr_o;
        end
    end

    task automatic reset_dut(input string tag);
        rst_i     = 1'b1;
        enable_i  = 1'b0;
        flush_i   = 1'b0;
        err_clr_i = 1'b0;
        m_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq({tag, "_rst_busy"}, busy_o, 1'b0);
        check_eq({tag, "_rst_valid"}, m_valid_o, 1'b0);
        check_eq({tag, "_rst_err"}, err_o, 1'b0);
        check_eq({tag, "_rst_words"}, words_read_o, 32'h0);
        check_eq({tag, "_rst_req"}, {sys_ren_o, sys_wen_o}, 2'b00);
        check_eq({tag, "_rst_addr"}, sys_addr_o, 32'h0);
        check_eq({tag, "_rst_wdata"}, sys_wdata_o, 32'h0);
        n_reqs = 0; n_cnt_reads = 0; n_data_reads = 0; n_writes = 0;
        last_cnt_cyc = -1; cnt_period = 0; last_data_cyc = -1; min_data_gap = 1000000;
        run_len = 0; req_while_valid = 0;
        runs.delete(); wr_addr.delete(); wr_data.delete(); recv.delete(); cnt_q.delete();
        rsp_pend = 1'b0; rsp_mute = 1'b0; data_err_once = 1'b0;
        data_next = 32'h0; data_step = 32'h1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_recv(input int n, input int bound, input string tag);
        for (int k = 0; k < bound && recv.size() < n; k++) @(negedge clk_i);
        check_eq({tag, "_recv_done"}, recv.size() >= n, 1'b1);
    endtask

    initial begin
        bit   found;
        int   dly;
        int   snap;
        logic [13:0] data0;
        bit   stable;

        // Basic three-word drain
        reset_dut("t1");
        cnt_q.push_back(32'd3);
        data_next = 32'h11;
        data_step = 32'h11;
        enable_i = 1'b1;
        wait_recv(3, 200, "t1");
        enable_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check_eq("t1_w0", recv[0], 14'h011);
        check_eq("t1_w1", recv[1], 14'h022);
        check_eq("t1_w2", recv[2], 14'h033);
        check_eq("t1_cnt_reads", n_cnt_reads, 1);
        check_eq("t1_data_reads", n_data_reads, 3);
        check_eq("t1_words", words_read_o, 32'd3);
        check_eq("t1_data_gap", min_data_gap, 4);
        check_eq("t1_req_while_valid", req_while_valid, 0);

        // Empty FIFO: periodic polling only
        reset_dut("t2");
        enable_i = 1'b1;
        repeat (60) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (15) @(negedge clk_i);
        check_eq("t2_poll_period", cnt_period, 11);
        check_eq("t2_polls_ge5", n_cnt_reads >= 5, 1'b1);
        check_eq("t2_data_reads", n_data_reads, 0);
        check_eq("t2_no_samples", recv.size(), 0);
        check_eq("t2_valid", m_valid_o, 1'b0);

        // Count above MAX_BURST splits into 64 + 36
        reset_dut("t3");
        cnt_q.push_back(32'd100);
        cnt_q.push_back(32'd36);
        enable_i = 1'b1;
        wait_recv(100, 2000, "t3");
        repeat (10) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check_eq("t3_runs", runs.size() >= 2, 1'b1);
        check_eq("t3_run0", runs[0], 64);
        check_eq("t3_run1", runs[1], 36);
        check_eq("t3_data_reads", n_data_reads, 100);
        check_eq("t3_words", words_read_o, 32'd100);
        check_eq("t3_w64", recv[64], 14'd64);
        check_eq("t3_w99", recv[99], 14'd99);

        // Sink stall holds the sample and the bus
        reset_dut("t4");
        cnt_q.push_back(32'd4);
        data_next = 32'h100;
        m_ready_i = 1'b0;
        enable_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_i);
            if (m_valid_o) found = 1'b1;
        end
        check_eq("t4_first_valid", found, 1'b1);
        data0 = m_data_o;
        snap = n_reqs;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (!m_valid_o || m_data_o != data0) stable = 1'b0;
        end
        check_eq("t4_first_data", data0, 14'h100);
        check_eq("t4_stall_stable", stable, 1'b1);
        check_eq("t4_stall_no_req", n_reqs - snap, 0);
        m_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("t4_valid_drop", m_valid_o, 1'b0);
        wait_recv(4, 200, "t4");
        enable_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check_eq("t4_w3", recv[3], 14'h103);
        check_eq("t4_req_while_valid", req_while_valid, 0);

        // Missing ack times out and blocks the bus until cleared
        reset_dut("t5");
        rsp_mute = 1'b1;
        enable_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            if (sys_ren_o) found = 1'b1;
        end
        check_eq("t5_req", found, 1'b1);
        found = 1'b0;
        dly = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk_i);
            if (err_o) begin
                found = 1'b1;
                dly = k;
            end
        end
        check_eq("t5_tmo_delay", dly, 17);
        check_eq("t5_busy", busy_o, 1'b0);
        snap = n_reqs;
        repeat (30) @(negedge clk_i);
        check_eq("t5_no_req", n_reqs - snap, 0);
        check_eq("t5_err_sticky", err_o, 1'b1);
        rsp_mute = 1'b0;
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check_eq("t5_err_clr", err_o, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk_i);
            if (sys_ren_o && sys_addr_o == A_CNT) found = 1'b1;
        end
        check_eq("t5_resume", found, 1'b1);
        enable_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Flush in the middle of a five-word burst
        reset_dut("t6");
        cnt_q.push_back(32'd5);
        data_next = 32'h200;
        enable_i = 1'b1;
        for (int k = 0; k < 100 && n_data_reads < 2; k++) @(negedge clk_i);
        check_eq("t6_reached_w2", n_data_reads, 2);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        for (int k = 0; k < 100 && n_writes < 2; k++) @(negedge clk_i);
        repeat (10) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check_eq("t6_samples", recv.size(), 2);
        check_eq("t6_w1", recv[1], 14'h201);
        check_eq("t6_data_reads", n_data_reads, 2);
        check_eq("t6_writes", n_writes, 2);
        check_eq("t6_wr0_addr", wr_addr[0], A_RST);
        check_eq("t6_wr0_data", wr_data[0], 32'h1);
        check_eq("t6_wr1_addr", wr_addr[1], A_RST);
        check_eq("t6_wr1_data", wr_data[1], 32'h0);

        // Bus error on a data ack drops the word
        reset_dut("t7");
        cnt_q.push_back(32'd2);
        data_err_once = 1'b1;
        enable_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk_i);
            if (err_o) found = 1'b1;
        end
        check_eq("t7_err", found, 1'b1);
        repeat (10) @(negedge clk_i);
        check_eq("t7_samples", recv.size(), 0);
        check_eq("t7_words", words_read_o, 32'd0);
        check_eq("t7_busy", busy_o, 1'b0);
        check_eq("t7_data_reads", n_data_reads, 1);
        enable_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
